maze_mover: RTL and testbench
=============================

Name: maze_mover

Overview:
- Player-position controller; the read-side client of the maze map ROM (8 rows × 8 cells, 1 = open, 0 = wall).
- Accepts single-step move requests (up/right/down/left) and bounds-checks the target cell.
- Fetches the target row from the map ROM over its en/addr/data port (1-cycle registered read) and commits the move only if the target cell is open.
- Reports completion and result, and flags arrival at the goal cell.

Parameters:
- START_X, 0, reset column of player (0..7)
- START_Y, 0, reset row of player (0..7)
- GOAL_X, 7, goal column
- GOAL_Y, 7, goal row

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- move_valid  in  1  move request present
- move_dir  in  2  direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
- move_ready  out  1  block can accept a request this cycle
- move_done  out  1  one-cycle pulse: request finished
- move_ok  out  1  valid with move_done: 1 = moved, 0 = rejected (wall or edge)
- pos_x  out  3  current column
- pos_y  out  3  current row
- at_goal  out  1  pos == (GOAL_X, GOAL_Y)
- rom_en  out  1  map ROM read enable
- rom_addr  out  3  map ROM row address
- rom_data  in  9  map ROM row; bits [7:0] used, bit 8 ignored; column x = rom_data[7-x]

Behaviour:
- Reset (async, rst_n=0): state IDLE, pos=(START_X,START_Y), move_ready=1, move_done=0, move_ok=0, rom_en=0, rom_addr=0. at_goal follows pos combinationally.
- Reset asserted mid-fetch aborts the request. No move_done is issued, and pos returns to start.
- FSM states: IDLE, FETCH, EVAL.
- IDLE:
  - move_ready=1.
  - Handshake is move_valid && move_ready at a rising edge. move_dir is sampled only then.
  - Target computed from pos and move_dir.
  - Out of bounds (x=0 left, x=7 right, y=0 up, y=7 down): no ROM access, stay IDLE, register move_done=1, move_ok=0. The pulse appears in the cycle after acceptance. Coordinates never wrap.
  - In bounds: latch target (tx, ty), go to FETCH.
- FETCH (1 cycle): rom_en=1, rom_addr=ty, move_ready=0. Next: EVAL.
- EVAL (1 cycle):
  - rom_data is valid.
  - If rom_data[7-tx]=1: pos<=(tx,ty), move_ok<=1. Otherwise pos is unchanged and move_ok<=0.
  - move_done<=1, go to IDLE.
- Latency: in-bounds request accepted at edge 0 → move_done and the updated pos are visible in cycle 3 (after edge 2). Edge reject → move_done in cycle 1.
- move_done is high for exactly one cycle. move_ok holds its value until the next move_done.
- move_ready is 1 in IDLE, including the move_done cycle, so back-to-back requests are allowed.
- rom_en is high only in FETCH, exactly one cycle per in-bounds request. rom_addr holds its last value otherwise.
- move_valid while not ready is ignored (no queueing).
- Moves at the goal are still processed normally. at_goal clears if the player leaves.

Decomposition:
- maze_pkg holds:
  - MAP_DIM=8, COORD_W=3
  - direction constants DIR_UP/RIGHT/DOWN/LEFT
  - FSM state encoding
  - the column-to-bit mapping (bit = 7-x)
  - ROM data width 9
- One natural combinational sub-module: maze_step_calc, inputs (x, y, dir), outputs (tx, ty, in_bounds). It is reused later by any auto-solver.

Test Plan:
- Map ROM #1 connected, relevant rows: row0=11111111, row1=10000001, row2=11101111.
- Reset, START=(0,0): after rst_n release, pos=(0,0), move_ready=1, move_done=0, rom_en=0, at_goal=0.
- From (0,0), request up (00): move_done in cycle 1 with move_ok=0, rom_en never asserted, pos stays (0,0).
- From (0,0), request down (10): rom_en=1 with rom_addr=1 for exactly one cycle; move_done in cycle 3 with move_ok=1, pos=(0,1).
- From (0,1), request right (01): row1 bit6=0, so move_ok=0 and pos stays (0,1). Then request down: row2 bit7=1, so pos=(0,2), move_ok=1.
- Reset mid-operation: accept a down request, drop rst_n during FETCH → immediately pos=(START_X,START_Y), rom_en=0, no move_done pulse after release.
- Goal and back-to-back moves: START=(6,7), GOAL=(7,7), request right → row7 bit0=0 so it is rejected and at_goal stays 0. Repeat with a modelled ROM where row7 bit0=1 → pos=(7,7), at_goal=1. Issue a new request in the move_done cycle → it is accepted with no bubble.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared map geometry, direction codes, FSM states and column mapping
package maze_pkg;

    localparam int MAP_DIM = 8;
    localparam int COORD_W = 3;
    localparam int ROM_W   = 9;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {IDLE, FETCH, EVAL} state_t;

    // Column 0 sits in the MSB of a map row
    function automatic logic [COORD_W-1:0] col_bit(input logic [COORD_W-1:0] x);
        return COORD_W'(MAP_DIM - 1) - x;
    endfunction

endpackage

// File: rtl/maze_if.sv
// maze_if: move request/result channel plus the map ROM read port of the mover
interface maze_if;
    import maze_pkg::*;

    logic               move_valid;
    logic [1:0]         move_dir;
    logic               move_ready;
    logic               move_done;
    logic               move_ok;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               at_goal;
    logic               rom_en;
    logic [COORD_W-1:0] rom_addr;
    logic [ROM_W-1:0]   rom_data;

    modport master (
        output move_valid, move_dir, rom_data,
        input  move_ready, move_done, move_ok, pos_x, pos_y, at_goal, rom_en, rom_addr
    );

    modport slave (
        input  move_valid, move_dir, rom_data,
        output move_ready, move_done, move_ok, pos_x, pos_y, at_goal, rom_en, rom_addr
    );

endinterface

// File: rtl/maze_step_calc.sv
// maze_step_calc: target cell of a single step and whether it stays on the map
module maze_step_calc
    import maze_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         dir,
    output logic [COORD_W-1:0] tx,
    output logic [COORD_W-1:0] ty,
    output logic               in_bounds
);

    localparam logic [COORD_W-1:0] MAX = COORD_W'(MAP_DIM - 1);

    // Wrapped targets are harmless: in_bounds vetoes them before use
    always_comb begin
        tx        = (dir == DIR_RIGHT) ? x + 1'b1 : (dir == DIR_LEFT) ? x - 1'b1 : x;
        ty        = (dir == DIR_DOWN)  ? y + 1'b1 : (dir == DIR_UP)   ? y - 1'b1 : y;
        in_bounds = !((dir == DIR_UP    && y == '0)  ||
                      (dir == DIR_DOWN  && y == MAX) ||
                      (dir == DIR_LEFT  && x == '0)  ||
                      (dir == DIR_RIGHT && x == MAX));
    end

endmodule

// File: rtl/maze_mover.sv
// maze_mover: player position controller that validates steps against the map ROM
module maze_mover
    import maze_pkg::*;
#(
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 7,
    parameter int GOAL_Y  = 7
) (
    input  logic clk,
    input  logic rst_n,
    maze_if.slave bus
);

    state_t             state;
    logic [COORD_W-1:0] tx, ty, tx_q, ty_q;
    logic               in_bounds;
    logic               cell_open;

    maze_step_calc u_step (
        .x         (bus.pos_x),
        .y         (bus.pos_y),
        .dir       (bus.move_dir),
        .tx        (tx),
        .ty        (ty),
        .in_bounds (in_bounds)
    );

    assign cell_open   = bus.rom_data[{1'b0, col_bit(tx_q)}];
    assign bus.at_goal = (bus.pos_x == COORD_W'(GOAL_X)) && (bus.pos_y == COORD_W'(GOAL_Y));

    // Request FSM: edge rejects finish in IDLE, in-bounds steps read one ROM row then commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.pos_x      <= COORD_W'(START_X);
            bus.pos_y      <= COORD_W'(START_Y);
            bus.move_ready <= 1'b1;
            bus.move_done  <= 1'b0;
            bus.move_ok    <= 1'b0;
            bus.rom_en     <= 1'b0;
            bus.rom_addr   <= '0;
            tx_q           <= '0;
            ty_q           <= '0;
        end else begin
            bus.move_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.move_valid && bus.move_ready) begin
                        if (in_bounds) begin
                            tx_q           <= tx;
                            ty_q           <= ty;
                            bus.rom_en     <= 1'b1;
                            bus.rom_addr   <= ty;
                            bus.move_ready <= 1'b0;
                            state          <= FETCH;
                        end else begin
                            bus.move_done <= 1'b1;
                            bus.move_ok   <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    bus.rom_en <= 1'b0;
                    state      <= EVAL;
                end
                EVAL: begin
                    if (cell_open) begin
                        bus.pos_x <= tx_q;
                        bus.pos_y <= ty_q;
                    end
                    bus.move_ok    <= cell_open;
                    bus.move_done  <= 1'b1;
                    bus.move_ready <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_mover.sv
// tb_maze_mover: scoreboard bench for two movers sharing a modelled map ROM
module tb_maze_mover;
    import maze_pkg::*;

    typedef struct {
        logic       ok;
        logic [2:0] x;
        logic [2:0] y;
        int         due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   rom_cnt_a;
    int   rom_cnt_b;
    int   last_acc;
    logic [2:0] last_addr_a;
    logic [7:0] map [8];
    exp_t qa[$];
    exp_t qb[$];

    maze_if ia ();
    maze_if ib ();

    maze_mover #(.START_X(0), .START_Y(0), .GOAL_X(7), .GOAL_Y(7)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    maze_mover #(.START_X(6), .START_Y(7), .GOAL_X(7), .GOAL_Y(7)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM read; bit 8 is driven high to prove it is ignored
    always @(posedge clk) begin
        if (ia.rom_en) ia.rom_data <= {1'b1, map[ia.rom_addr]};
        if (ib.rom_en) ib.rom_data <= {1'b1, map[ib.rom_addr]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every move_done pops one expectation and checks result, position and timing
    always @(negedge clk) begin
        exp_t e;
        if (ia.rom_en) begin
            rom_cnt_a++;
            last_addr_a = ia.rom_addr;
        end
        if (ib.rom_en) rom_cnt_b++;
        if (ia.move_done) begin
            if (qa.size() == 0) check("a_unexpected_done", 1, 0);
            else begin
                e = qa.pop_front();
                check("a_ok", 32'(ia.move_ok), 32'(e.ok));
                check("a_pos", 32'({ia.pos_x, ia.pos_y}), 32'({e.x, e.y}));
                check("a_latency", cyc, e.due);
            end
        end
        if (ib.move_done) begin
            if (qb.size() == 0) check("b_unexpected_done", 1, 0);
            else begin
                e = qb.pop_front();
                check("b_ok", 32'(ib.move_ok), 32'(e.ok));
                check("b_pos", 32'({ib.pos_x, ib.pos_y}), 32'({e.x, e.y}));
                check("b_latency", cyc, e.due);
            end
        end
    end

    task automatic drive(input bit sel, input logic v, input logic [1:0] d);
        if (sel) begin
            ib.move_valid = v;
            ib.move_dir   = d;
        end else begin
            ia.move_valid = v;
            ia.move_dir   = d;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ib.move_ready : ia.move_ready;
    endfunction

    function automatic logic done(input bit sel);
        return sel ? ib.move_done : ia.move_done;
    endfunction

    task automatic issue(input bit sel, input logic [1:0] d, input bit push, input bit inb,
                         input logic ok, input logic [2:0] x, input logic [2:0] y);
        int   n;
        exp_t e;
        n = 0;
        drive(sel, 1'b1, d);
        while (!rdy(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(rdy(sel)), 1);
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (push) begin
            e.ok  = ok;
            e.x   = x;
            e.y   = y;
            e.due = cyc + (inb ? 2 : 0);
            if (sel) qb.push_back(e);
            else qa.push_back(e);
        end
        drive(sel, 1'b0, d);
    endtask

    task automatic drain(input bit sel);
        int n;
        n = 0;
        while ((sel ? qb.size() : qa.size()) > 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", sel ? qb.size() : qa.size(), 0);
        @(negedge clk);
        check("done_one_cycle", 32'(done(sel)), 0);
    endtask

    task automatic wait_done(input bit sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done(sel) && n < 20);
        check("done_seen", 32'(done(sel)), 1);
    endtask

    initial begin
        int c0;
        int dc;
        for (int i = 0; i < 8; i++) map[i] = 8'h00;
        map[0] = 8'b1111_1111;
        map[1] = 8'b1000_0001;
        map[2] = 8'b1110_1111;
        map[7] = 8'b1111_1110;
        cyc = 0;
        n_tests = 0;
        n_fail = 0;
        rom_cnt_a = 0;
        rom_cnt_b = 0;
        last_addr_a = '0;
        drive(0, 1'b0, DIR_UP);
        drive(1, 1'b0, DIR_UP);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pos", 32'({ia.pos_x, ia.pos_y}), 0);
        check("rst_ready", 32'(ia.move_ready), 1);
        check("rst_done", 32'(ia.move_done), 0);
        check("rst_ok", 32'(ia.move_ok), 0);
        check("rst_rom_en", 32'(ia.rom_en), 0);
        check("rst_rom_addr", 32'(ia.rom_addr), 0);
        check("rst_at_goal", 32'(ia.at_goal), 0);

        c0 = rom_cnt_a;
        issue(0, DIR_UP, 1, 0, 1'b0, 3'd0, 3'd0);
        drain(0);
        check("up_edge_no_rom", rom_cnt_a - c0, 0);

        c0 = rom_cnt_a;
        issue(0, DIR_DOWN, 1, 1, 1'b1, 3'd0, 3'd1);
        drain(0);
        check("down_rom_once", rom_cnt_a - c0, 1);
        check("down_rom_addr", 32'(last_addr_a), 1);

        issue(0, DIR_RIGHT, 1, 1, 1'b0, 3'd0, 3'd1);
        drain(0);
        check("right_wall_addr", 32'(last_addr_a), 1);
        check("ok_held", 32'(ia.move_ok), 0);

        issue(0, DIR_DOWN, 1, 1, 1'b1, 3'd0, 3'd2);
        drain(0);
        check("down2_rom_addr", 32'(last_addr_a), 2);
        check("ok_held_hi", 32'(ia.move_ok), 1);

        c0 = rom_cnt_a;
        issue(0, DIR_LEFT, 1, 0, 1'b0, 3'd0, 3'd2);
        drain(0);
        check("left_edge_no_rom", rom_cnt_a - c0, 0);
        check("a_not_goal", 32'(ia.at_goal), 0);

        issue(0, DIR_DOWN, 0, 1, 1'b0, 3'd0, 3'd0);
        check("fetch_rom_en", 32'(ia.rom_en), 1);
        rst_n = 1'b0;
        #1;
        check("abort_pos", 32'({ia.pos_x, ia.pos_y}), 0);
        check("abort_rom_en", 32'(ia.rom_en), 0);
        check("abort_ready", 32'(ia.move_ready), 1);
        check("abort_done", 32'(ia.move_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("after_abort_pos", 32'({ia.pos_x, ia.pos_y}), 0);

        check("b_start_pos", 32'({ib.pos_x, ib.pos_y}), 32'({3'd6, 3'd7}));
        check("b_start_goal", 32'(ib.at_goal), 0);
        issue(1, DIR_RIGHT, 1, 1, 1'b0, 3'd6, 3'd7);
        drain(1);
        check("b_wall_not_goal", 32'(ib.at_goal), 0);

        map[7] = 8'b1111_1111;
        c0 = rom_cnt_b;
        issue(1, DIR_RIGHT, 1, 1, 1'b1, 3'd7, 3'd7);
        wait_done(1);
        check("b_at_goal", 32'(ib.at_goal), 1);
        check("b_rom_once", rom_cnt_b - c0, 1);
        dc = cyc;
        issue(1, DIR_RIGHT, 1, 0, 1'b0, 3'd7, 3'd7);
        check("b2b_accept_1", last_acc, dc + 1);
        wait_done(1);
        dc = cyc;
        issue(1, DIR_LEFT, 1, 1, 1'b1, 3'd6, 3'd7);
        check("b2b_accept_2", last_acc, dc + 1);
        drain(1);
        check("b_left_goal", 32'(ib.at_goal), 0);

        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
